// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter among NREQ requesters
module uart_tx_scheduler #(
   parameter int NREQ       = 4,
   parameter int DATA_W     = 7,
   parameter int START_HOLD = 16,
   parameter int TIMEOUT    = 65535
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*DATA_W-1:0]     req_data,
   output logic [NREQ-1:0]            grant,
   output logic [NREQ-1:0]            done,
   output logic                       tx_start,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_sent,
   output logic                       busy,
   output logic [$clog2(NREQ)-1:0]    cur_id,
   output logic                       timeout_err
);

   localparam int IDW = $clog2(NREQ);
   localparam int HW  = $clog2(START_HOLD + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [IDW-1:0]      cur_id_q, cur_id_d;
   logic [IDW-1:0]      last_q, last_d;
   logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
   logic [TW-1:0]       wait_cnt_q, wait_cnt_d;
   logic                sent_seen_q, sent_seen_d;
   logic                to_flag_q, to_flag_d;
   logic                sync1_q, sync2_q, sync3_q;

   logic                any_req;
   logic [IDW-1:0]      sel_idx;
   logic [IDW-1:0]      cand;
   logic [NREQ-1:0]     sel_grant;
   logic [DATA_W-1:0]   sel_data;
   logic                sent_rise;
   logic                hold_last;
   logic                wait_last;

   assign any_req   = |req;
   assign sent_rise = sync2_q & ~sync3_q;
   assign hold_last = (hold_cnt_q == HW'(START_HOLD - 1));
   assign wait_last = (wait_cnt_q == TW'(TIMEOUT - 1));

   // Round-robin pick: scan from last+NREQ down to last+1 so the nearest pending requester wins
   always_comb begin
      sel_idx   = '0;
      cand      = '0;
      sel_grant = '0;
      sel_data  = '0;
      for (int off = NREQ; off >= 1; off--) begin
         cand = IDW'((int'(last_q) + off) % NREQ);
         for (int i = 0; i < NREQ; i++) begin
            if ((IDW'(i) == cand) && req[i]) begin
               sel_idx = cand;
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == sel_idx) begin
            sel_grant[i] = 1'b1;
            sel_data     = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // FSM state register; reset forces IDLE so tx_start drops without waiting for a clock
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: START holds for START_HOLD cycles, WAIT ends on a fresh tx_sent edge or timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_req) state_d = S_START;
         S_START: if (hold_last) state_d = S_WAIT;
         S_WAIT:  if (sent_seen_q || wait_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state and the registered transaction context
   always_comb begin
      tx_start    = (state_q == S_START);
      busy        = (state_q != S_IDLE);
      timeout_err = (state_q == S_DONE) && to_flag_q;
      done        = '0;
      if (state_q == S_DONE) begin
         for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == cur_id_q) begin
               done[i] = 1'b1;
            end
         end
      end
   end

   // Datapath next-state: latch the winner at grant time, run the phase counters, track tx_sent edges
   always_comb begin
      grant_d     = grant_q;
      tx_data_d   = tx_data_q;
      cur_id_d    = cur_id_q;
      last_d      = last_q;
      hold_cnt_d  = '0;
      wait_cnt_d  = '0;
      sent_seen_d = sent_seen_q;
      to_flag_d   = to_flag_q;
      case (state_q)
         S_IDLE: begin
            sent_seen_d = 1'b0;
            to_flag_d   = 1'b0;
            if (any_req) begin
               grant_d   = sel_grant;
               tx_data_d = sel_data;
               cur_id_d  = sel_idx;
            end
         end
         S_START: begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            if (sent_rise) sent_seen_d = 1'b1;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + TW'(1);
            if (sent_rise) sent_seen_d = 1'b1;
            if (!sent_seen_q && wait_last) to_flag_d = 1'b1;
         end
         S_DONE: begin
            grant_d = '0;
            last_d  = cur_id_q;
         end
         default: ;
      endcase
   end

   // Datapath registers plus the two-flop tx_sent synchronizer and its edge-history flop
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         grant_q     <= '0;
         tx_data_q   <= '0;
         cur_id_q    <= '0;
         last_q      <= IDW'(NREQ - 1);
         hold_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         sent_seen_q <= 1'b0;
         to_flag_q   <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
      end else begin
         grant_q     <= grant_d;
         tx_data_q   <= tx_data_d;
         cur_id_q    <= cur_id_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         sent_seen_q <= sent_seen_d;
         to_flag_q   <= to_flag_d;
         sync1_q     <= tx_sent;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
      end
   end

   assign grant   = grant_q;
   assign tx_data = tx_data_q;
   assign cur_id  = cur_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

   localparam int NREQ       = 4;
   localparam int DATA_W     = 7;
   localparam int START_HOLD = 16;
   localparam int TIMEOUT    = 100;

   logic                   clk;
   logic                   rstN;
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        grant;
   logic [NREQ-1:0]        done;
   logic                   tx_start;
   logic [DATA_W-1:0]      tx_data;
   logic                   tx_sent;
   logic                   busy;
   logic [1:0]             cur_id;
   logic                   timeout_err;

   int checks;
   int failures;

   logic [DATA_W-1:0] exp_data [NREQ];

   uart_tx_scheduler #(
      .NREQ(NREQ), .DATA_W(DATA_W), .START_HOLD(START_HOLD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstN(rstN), .req(req), .req_data(req_data),
      .grant(grant), .done(done), .tx_start(tx_start), .tx_data(tx_data),
      .tx_sent(tx_sent), .busy(busy), .cur_id(cur_id), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rstN    = 1'b0;
      req     = '0;
      tx_sent = 1'b0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
   endtask

   // Drives one transaction: waits for grant, optionally pulses tx_sent, waits for done
   task automatic do_txn(input logic [NREQ-1:0] next_req, input bit send,
                         output logic [NREQ-1:0] g, output logic [DATA_W-1:0] d,
                         output logic [NREQ-1:0] dn, output logic to, output bit ok);
      int w;
      ok = 1'b1; g = '0; d = '0; dn = '0; to = 1'b0;
      w = 0;
      while (!busy && w < 20) begin @(negedge clk); w++; end
      if (!busy) begin ok = 1'b0; return; end
      g = grant;
      d = tx_data;
      w = 0;
      while (tx_start && w < 40) begin @(negedge clk); w++; end
      if (send) begin
         repeat (5) @(negedge clk);
         tx_sent = 1'b1;
         repeat (2) @(negedge clk);
         tx_sent = 1'b0;
      end
      w = 0;
      while (done == '0 && w < TIMEOUT + 50) begin @(negedge clk); w++; end
      if (done == '0) begin ok = 1'b0; return; end
      dn  = done;
      to  = timeout_err;
      req = next_req;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstN = 1'b0; req = '0; tx_sent = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({grant, done, tx_start, tx_data, busy, cur_id, timeout_err} !== '0) begin
         failures++;
         $display("FAIL reset_in: got grant=%b done=%b start=%b data=%h busy=%b id=%0d to=%b expected all 0",
                  grant, done, tx_start, tx_data, busy, cur_id, timeout_err);
      end
      rstN = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({grant, busy, tx_start} !== '0) begin
         failures++;
         $display("FAIL reset_idle: got grant=%b busy=%b start=%b expected 0", grant, busy, tx_start);
      end
   endtask

   task automatic test_basic();
      int hc;
      int w;
      do_reset();
      req = 4'b0001;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_grant: got grant=%b busy=%b expected 0001/1", grant, busy);
      end
      checks++;
      if (tx_data !== 7'h55) begin
         failures++;
         $display("FAIL basic_data: got %h expected 55", tx_data);
      end
      hc = 0;
      while (tx_start && hc < 40) begin hc++; @(negedge clk); end
      checks++;
      if (hc != START_HOLD) begin
         failures++;
         $display("FAIL basic_start_hold: got %0d cycles expected %0d", hc, START_HOLD);
      end
      repeat (24) @(negedge clk);
      tx_sent = 1'b1;
      repeat (2) @(negedge clk);
      tx_sent = 1'b0;
      w = 0;
      while (done == '0 && w < 10) begin @(negedge clk); w++; end
      checks++;
      if (done !== 4'b0001 || timeout_err !== 1'b0 || tx_data !== 7'h55) begin
         failures++;
         $display("FAIL basic_done: got done=%b to=%b data=%h expected 0001/0/55", done, timeout_err, tx_data);
      end
      @(negedge clk);
      checks++;
      if (done !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000) begin
         failures++;
         $display("FAIL basic_after: got done=%b busy=%b grant=%b expected 0/0/0", done, busy, grant);
      end
      req = '0;
   endtask

   task automatic test_back_to_back();
      logic [NREQ-1:0]   g, dn, eg, nr;
      logic [DATA_W-1:0] d;
      logic              to;
      bit                ok;
      int                cnt [NREQ];
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         nr = (k == 4) ? 4'b0000 : 4'b1111;
         do_txn(nr, 1'b1, g, d, dn, to, ok);
         eg = 4'(1 << (k % NREQ));
         checks++;
         if (!ok || g !== eg || dn !== eg || d !== exp_data[k % NREQ] || to !== 1'b0) begin
            failures++;
            $display("FAIL rr_txn[%0d]: got ok=%0d grant=%b done=%b data=%h to=%b expected grant/done=%b data=%h",
                     k, ok, g, dn, d, to, eg, exp_data[k % NREQ]);
         end
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle_gap[%0d]: got busy=%b expected 0", k, busy);
         end
         if (k < NREQ) begin
            for (int i = 0; i < NREQ; i++) if (dn[i]) cnt[i]++;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         checks++;
         if (cnt[i] != 1) begin
            failures++;
            $display("FAIL rr_fair[%0d]: got %0d done pulses expected 1", i, cnt[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [NREQ-1:0]   g, dn;
      logic [DATA_W-1:0] d;
      logic              to;
      bit                ok;
      do_reset();
      req = 4'b0010;
      do_txn(4'b0011, 1'b1, g, d, dn, to, ok);
      checks++;
      if (!ok || g !== 4'b0010 || d !== 7'h2A) begin
         failures++;
         $display("FAIL wrap_first: got ok=%0d grant=%b data=%h expected 0010/2A", ok, g, d);
      end
      do_txn(4'b0000, 1'b1, g, d, dn, to, ok);
      checks++;
      if (!ok || g !== 4'b0001 || dn !== 4'b0001) begin
         failures++;
         $display("FAIL wrap_second: got ok=%0d grant=%b done=%b expected 0001", ok, g, dn);
      end
   endtask

   task automatic test_timeout();
      logic [NREQ-1:0]   g, dn;
      logic [DATA_W-1:0] d;
      logic              to;
      bit                ok;
      int                w;
      int                cnt;
      do_reset();
      req = 4'b0100;
      w = 0;
      while (!busy && w < 20) begin @(negedge clk); w++; end
      w = 0;
      while (tx_start && w < 40) begin @(negedge clk); w++; end
      req = 4'b0000;
      cnt = 0;
      while (done == '0 && cnt < TIMEOUT + 20) begin cnt++; @(negedge clk); end
      checks++;
      if (cnt != TIMEOUT) begin
         failures++;
         $display("FAIL timeout_cycles: got %0d expected %0d", cnt, TIMEOUT);
      end
      checks++;
      if (done !== 4'b0100 || timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_pulse: got done=%b to=%b expected 0100/1", done, timeout_err);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || done !== 4'b0000) begin
         failures++;
         $display("FAIL timeout_width: got done=%b to=%b expected 0/0", done, timeout_err);
      end
      req = 4'b0001;
      do_txn(4'b0000, 1'b1, g, d, dn, to, ok);
      checks++;
      if (!ok || g !== 4'b0001 || dn !== 4'b0001 || to !== 1'b0) begin
         failures++;
         $display("FAIL timeout_next: got ok=%0d grant=%b done=%b to=%b expected 0001/0001/0", ok, g, dn, to);
      end
   endtask

   task automatic test_stale_sent();
      bit seen;
      int w;
      do_reset();
      tx_sent = 1'b1;
      repeat (5) @(negedge clk);
      req = 4'b0001;
      @(negedge clk);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin @(negedge clk); if (done != '0) seen = 1'b1; end
      tx_sent = 1'b0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); if (done != '0) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL stale_no_done: got early done=%b expected 0", seen);
      end
      req = 4'b0000;
      tx_sent = 1'b1;
      w = 0;
      while (done == '0 && w < 10) begin @(negedge clk); w++; end
      checks++;
      if (done !== 4'b0001 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL stale_done: got done=%b to=%b expected 0001/0", done, timeout_err);
      end
      tx_sent = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [NREQ-1:0]   g, dn;
      logic [DATA_W-1:0] d;
      logic              to;
      bit                ok;
      int                w;
      do_reset();
      req = 4'b0001;
      do_txn(4'b0100, 1'b1, g, d, dn, to, ok);
      w = 0;
      while (!busy && w < 20) begin @(negedge clk); w++; end
      repeat (5) @(negedge clk);
      checks++;
      if (tx_start !== 1'b1 || grant !== 4'b0100) begin
         failures++;
         $display("FAIL areset_pre: got start=%b grant=%b expected 1/0100", tx_start, grant);
      end
      #2 rstN = 1'b0;
      #1;
      checks++;
      if (tx_start !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL areset_instant: got start=%b grant=%b busy=%b expected 0/0/0", tx_start, grant, busy);
      end
      req = 4'b1111;
      @(negedge clk);
      rstN = 1'b1;
      do_txn(4'b0000, 1'b1, g, d, dn, to, ok);
      checks++;
      if (!ok || g !== 4'b0001 || dn !== 4'b0001) begin
         failures++;
         $display("FAIL areset_first: got ok=%0d grant=%b done=%b expected 0001", ok, g, dn);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_data = '{7'h55, 7'h2A, 7'h11, 7'h6C};
      req_data = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
      rstN     = 1'b0;
      req      = '0;
      tx_sent  = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_timeout();
      test_stale_sent();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
